pc_ctrl: RTL
============

Name: pc_ctrl

Overview:
Parametrised next-generation program-counter unit for the fetch stage. It holds the fetch PC and generates the sequential increment. It takes resolved redirects (branch/jump targets) from downstream and adds stall, exception entry/return (EPC save and restore) and a sticky halt state, under a fixed priority order. It feeds the instruction-memory address and the PC+INC value passed down the pipeline for link/branch arithmetic.

Parameters:
WIDTH, 16, address/PC width in bits
INC, 2, sequential increment in bytes; must be a power of two, at least 1
RESET_VEC, 0, PC value loaded on reset
EXC_VEC, 16'h0002, handler entry address loaded on siic; width WIDTH

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC (fetch/decode back-pressure)
redirect  in  1  taken branch/jump resolved downstream
redirect_addr  in  WIDTH  target for redirect
siic  in  1  illegal-instruction/exception request
rti  in  1  return from exception
halt  in  1  halt request
pc  out  WIDTH  current fetch address (registered)
pc_inc  out  WIDTH  pc + INC, combinational, modulo 2^WIDTH
pc_next  out  WIDTH  value pc will take at the next edge (combinational)
epc  out  WIDTH  saved return address (registered)
state  out  2  FSM state encoding, per package
err  out  1  sticky error flag

Behaviour:
- Clock `clk`; reset `rst` is synchronous and active-high. On reset: pc=RESET_VEC, epc=0, state=RUN, err=0. Reset overrides every other input in the same cycle.
- FSM states: RUN=0, EXC=1, HALTED=2; 3 is unused and must decode to HALTED.
- next-PC priority, highest first, evaluated each cycle:
  1. rst → RESET_VEC.
  2. state==HALTED → pc held. All inputs ignored except rst.
  3. halt → pc held; next state HALTED.
  4. siic in RUN → pc_next=EXC_VEC; epc←pc_inc; next state EXC.
  5. siic in EXC → err←1. siic is then ignored: epc is not overwritten, and evaluation continues at rule 6.
  6. rti in EXC → pc_next=epc; next state RUN.
  7. rti in RUN → err←1; rti is ignored and evaluation continues.
  8. redirect → pc_next=redirect_addr. Redirect beats stall, because a flush supersedes back-pressure.
  9. stall → pc held.
  10. otherwise → pc_inc.
- siic and redirect in the same cycle: siic wins. The redirect is dropped, because the faulting instruction is older.
- rti and redirect in the same cycle while in EXC: rti wins.
- Latency: pc updates one edge after the request. pc_next and pc_inc are valid in the same cycle as their inputs.
- Wrap-around: pc_inc at pc=2^WIDTH−INC equals 0. There is no carry output and no error.
- Misaligned redirect_addr (low log2(INC) bits nonzero): the target is loaded unchanged and err←1.
- err clears only on rst.
- halt while stalled: halted anyway. The pc remains frozen.
- Halt is terminal until rst. A reset asserted mid-EXC returns to RUN and clears epc.

Decomposition:
- Shared package pc_ctrl_pkg holds the state encodings RUN/EXC/HALTED and the next-PC source select constants SRC_RST, SRC_HOLD, SRC_EXC, SRC_EPC, SRC_REDIR, SRC_INC.
- One natural sub-module, pc_ctrl_fsm. It takes the state plus the control inputs and produces the source select, next state, epc load enable and err set. The top level holds the pc, epc and err registers, the incrementer and the source mux.
- Target size is roughly 150–250 lines total.

Test Plan:
- Reset then 4 idle cycles (WIDTH=16, INC=2) → pc sequence 0,2,4,6,8; pc_inc one step ahead; err=0.
- At pc=0x0010, assert stall for 3 cycles, then redirect=1 with stall=1 and redirect_addr=0x0100 → pc holds 0x0010 for 3 cycles, then becomes 0x0100.
- At pc=0x0020, siic=1 together with redirect=1 to 0x0400 → pc=EXC_VEC, epc=0x0022, state=EXC. A second siic at a later cycle → err=1 and epc is still 0x0022. Then rti → pc=0x0022, state=RUN.
- rti in RUN at pc=0x0030 → err=1; pc advances to 0x0032.
- halt at pc=0x0040 → pc frozen at 0x0040 with state=HALTED across subsequent siic/redirect/rti pulses. rst → pc=RESET_VEC, state=RUN, err=0.
- Start from pc=0xFFFE (reach it via redirect), then one idle cycle → pc=0x0000. Separately, redirect to 0x0101 → pc=0x0101 and err=1.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: state encodings and next-PC source selects shared by pc_ctrl and its FSM
package pc_ctrl_pkg;
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] EXC    = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;
    localparam logic [2:0] SRC_RST   = 3'd0;
    localparam logic [2:0] SRC_HOLD  = 3'd1;
    localparam logic [2:0] SRC_EXC   = 3'd2;
    localparam logic [2:0] SRC_EPC   = 3'd3;
    localparam logic [2:0] SRC_REDIR = 3'd4;
    localparam logic [2:0] SRC_INC   = 3'd5;
    function automatic logic is_halted(input logic [1:0] st);
        return st[1];
    endfunction
endpackage

// File: rtl/pc_ctrl_fsm.sv
// pc_ctrl_fsm: prioritised next-PC source select, next state, epc load and err set
module pc_ctrl_fsm
    import pc_ctrl_pkg::*;
(
    input  logic       rst_i,
    input  logic [1:0] state_i,
    input  logic       stall_i,
    input  logic       redirect_i,
    input  logic       misaligned_i,
    input  logic       siic_i,
    input  logic       rti_i,
    input  logic       halt_i,
    output logic [2:0] src_o,
    output logic [1:0] state_d_o,
    output logic       epc_load_o,
    output logic       err_set_o
);
    logic in_exc;
    logic rti_ok;
    assign in_exc = state_i == EXC;
    assign rti_ok = rti_i && in_exc;
    always_comb begin
        src_o      = SRC_INC;
        state_d_o  = state_i;
        epc_load_o = 1'b0;
        err_set_o  = 1'b0;
        if (rst_i) begin
            src_o     = SRC_RST;
            state_d_o = RUN;
        end else if (is_halted(state_i) || halt_i) begin
            src_o     = SRC_HOLD;
            state_d_o = HALTED;
        end else if (siic_i && !in_exc) begin
            src_o      = SRC_EXC;
            state_d_o  = EXC;
            epc_load_o = 1'b1;
        end else begin
            err_set_o = (siic_i && in_exc) || (rti_i && !in_exc) || (!rti_ok && redirect_i && misaligned_i);
            src_o     = rti_ok ? SRC_EPC : redirect_i ? SRC_REDIR : stall_i ? SRC_HOLD : SRC_INC;
            state_d_o = rti_ok ? RUN : state_i;
        end
    end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch program counter with redirect, stall, exception entry/return and sticky halt
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               INC       = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_addr,
    input  logic             siic,
    input  logic             rti,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] pc_next,
    output logic [WIDTH-1:0] epc,
    output logic [1:0]       state,
    output logic             err
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
    logic [WIDTH-1:0] pc_q, epc_q, epc_d;
    logic [1:0]       state_q, state_d;
    logic             err_q, err_d;
    logic [2:0]       src;
    logic             epc_load, err_set;
    pc_ctrl_fsm u_fsm (
        .rst_i        (rst),
        .state_i      (state_q),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .misaligned_i (|(redirect_addr & ALIGN_MASK)),
        .siic_i       (siic),
        .rti_i        (rti),
        .halt_i       (halt),
        .src_o        (src),
        .state_d_o    (state_d),
        .epc_load_o   (epc_load),
        .err_set_o    (err_set)
    );
    assign pc_inc  = pc_q + WIDTH'(INC);
    assign pc_next = src == SRC_RST   ? RESET_VEC :
                     src == SRC_EXC   ? EXC_VEC :
                     src == SRC_EPC   ? epc_q :
                     src == SRC_REDIR ? redirect_addr :
                     src == SRC_INC   ? pc_inc : pc_q;
    assign epc_d = epc_load ? pc_inc : epc_q;
    assign err_d = err_q | err_set;
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            state_q <= RUN;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_next;
            epc_q   <= epc_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end
    assign pc    = pc_q;
    assign epc   = epc_q;
    assign state = state_q;
    assign err   = err_q;
endmodule
